// File: rtl/set_hit_counter.sv
// set_hit_counter: scores a stream of candidates against a configurable set-membership
// predicate and accumulates a saturating per-run hit count with a completion pulse.
module set_hit_counter #(
  parameter int NSETS = 3,
  parameter int CNT_W = 8,
  parameter int K_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       mode_i,
  input  logic [NSETS-1:0] mask_i,
  input  logic [K_W-1:0]   k_i,
  input  logic             valid_i,
  input  logic [NSETS-1:0] covered_i,
  input  logic             last_i,
  output logic             ready_o,
  output logic             hit_o,
  output logic             hit_valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o,
  output logic             busy_o,
  output logic             done_o
);

  // state | meaning
  // IDLE  | waiting for start_i, count held from previous run
  // RUN   | accepting candidates
  // FLUSH | last candidate in the stage register being scored
  // DONE  | count final, one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [2:0] M_ANY     = 3'd0;
  localparam logic [2:0] M_ALL     = 3'd1;
  localparam logic [2:0] M_PARITY  = 3'd2;
  localparam logic [2:0] M_EXACT   = 3'd3;
  localparam logic [2:0] M_ATLEAST = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]       r_mode;
  logic [NSETS-1:0] r_mask;
  logic [K_W-1:0]   r_k;
  logic             r_hit;
  logic             r_hit_valid;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_start;
  logic             w_accept;
  logic             w_hit;
  logic [NSETS-1:0] w_masked;
  logic [K_W-1:0]   w_pop;

  assign w_masked = covered_i & r_mask;

  // K_W is wide enough to hold NSETS, so the popcount cannot wrap
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NSETS; i++) begin
      w_pop = w_pop + K_W'(w_masked[i]);
    end
  end

  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      M_ANY:     w_hit = |w_masked;
      M_ALL:     w_hit = (w_masked == r_mask) && (|r_mask);
      M_PARITY:  w_hit = ^w_masked;
      M_EXACT:   w_hit = (w_pop == r_k);
      M_ATLEAST: w_hit = (w_pop >= r_k);
      default:   w_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        ready_o = 1'b1;
        busy_o  = 1'b1;
        if (valid_i && last_i) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy_o      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = valid_i & ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= '0;
      r_mask <= '0;
      r_k    <= '0;
    end else if (w_start) begin
      r_mode <= mode_i;
      r_mask <= mask_i;
      r_k    <= k_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit       <= 1'b0;
      r_hit_valid <= 1'b0;
    end else begin
      r_hit_valid <= w_accept;
      if (w_accept) begin
        r_hit <= w_hit;
      end
    end
  end

  // The count trails the hit stage by one cycle; no hit is in flight when a start is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_start) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (r_hit_valid && r_hit) begin
      if (r_count == CNT_MAX) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CNT_ONE;
      end
    end
  end

  assign hit_o       = r_hit;
  assign hit_valid_o = r_hit_valid;
  assign count_o     = r_count;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_set_hit_counter.sv
// Randomised scoreboard bench for set_hit_counter: the driver pushes expected hits and final
// counts from a behavioural model, a negedge monitor pops them when the DUT reports.
module tb_set_hit_counter;
  localparam int NSETS = 3;
  localparam int CNT_W = 8;
  localparam int K_W   = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [2:0]       mode_i;
  logic [NSETS-1:0] mask_i;
  logic [K_W-1:0]   k_i;
  logic             valid_i;
  logic [NSETS-1:0] covered_i;
  logic             last_i;
  logic             ready_o;
  logic             hit_o;
  logic             hit_valid_o;
  logic [CNT_W-1:0] count_o;
  logic             ovf_o;
  logic             busy_o;
  logic             done_o;

  set_hit_counter #(.NSETS(NSETS), .CNT_W(CNT_W), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .mask_i(mask_i), .k_i(k_i),
    .valid_i(valid_i), .covered_i(covered_i), .last_i(last_i), .ready_o(ready_o),
    .hit_o(hit_o), .hit_valid_o(hit_valid_o), .count_o(count_o), .ovf_o(ovf_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit exp_hit_q[$];
  int exp_cnt_q[$];
  bit exp_ovf_q[$];

  logic [NSETS-1:0] dir_cov[$];
  bit               dir_valid[$];

  logic [2:0]       m_mode;
  logic [NSETS-1:0] m_mask;
  int               m_k;
  int               m_cnt;
  bit               m_ovf;

  logic [2:0]       sw_mode[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3};
  logic [NSETS-1:0] sw_mask[7] = '{3'b100, 3'b110, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
  logic [K_W-1:0]   sw_k[7]    = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0};
  int               sw_exp[7]  = '{1, 0, 0, 1, 0, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [2:0] mode, input logic [NSETS-1:0] mask,
                                   input int k, input logic [NSETS-1:0] cov);
    int p;
    p = $countones(cov & mask);
    case (mode)
      3'd0:    return p > 0;
      3'd1:    return (mask != 0) && ((cov & mask) == mask);
      3'd2:    return (p % 2) == 1;
      3'd3:    return p == k;
      3'd4:    return p >= k;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (hit_valid_o) begin
        if (exp_hit_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL hit_unexpected: got hit_valid 1 expected no pending hit at %0t", $time);
        end else begin
          chk("hit", hit_o, exp_hit_q.pop_front());
        end
      end
      if (done_o) begin
        if (exp_cnt_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL done_unexpected: got done 1 expected no pending run at %0t", $time);
        end else begin
          chk("final_count", count_o, exp_cnt_q.pop_front());
          chk("final_ovf", ovf_o, exp_ovf_q.pop_front());
        end
      end
    end
  end

  task automatic start_cfg(input logic [2:0] mode, input logic [NSETS-1:0] mask,
                           input logic [K_W-1:0] k);
    start_i = 1'b1;
    mode_i  = mode;
    mask_i  = mask;
    k_i     = k;
    valid_i = 1'b0;
    last_i  = 1'b0;
    m_mode  = mode;
    m_mask  = mask;
    m_k     = int'(k);
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  // Called with start_i driven for the current cycle; returns in the DONE cycle.
  task automatic run_body(input int n, input bit gaps);
    bit v;
    bit is_last;
    bit h;
    logic [NSETS-1:0] cov;
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    @(posedge clk); #1;
    chk("run_ready", ready_o, 1);
    chk("run_busy", busy_o, 1);
    chk("run_count0", count_o, 0);
    chk("run_ovf0", ovf_o, 0);
    start_i = 1'b0;
    is_last = 1'b0;
    while (!is_last) begin
      if (dir_valid.size() > 0) v = dir_valid.pop_front();
      else if (gaps && cyc < 4 * n + 20) v = ($urandom_range(0, 2) != 0);
      else v = 1'b1;
      if (v && dir_cov.size() > 0) cov = dir_cov.pop_front();
      else cov = NSETS'($urandom);
      is_last   = v && (acc == n - 1);
      valid_i   = v;
      covered_i = cov;
      last_i    = v ? is_last : 1'($urandom_range(0, 1));
      mode_i    = 3'($urandom);
      mask_i    = NSETS'($urandom);
      k_i       = K_W'($urandom);
      start_i   = ($urandom_range(0, 7) == 0);
      if (v) begin
        h = model_hit(m_mode, m_mask, m_k, cov);
        exp_hit_q.push_back(h);
        if (h) begin
          if (m_cnt == CMAX) m_ovf = 1'b1;
          else m_cnt++;
        end
        acc++;
      end
      cyc++;
      @(posedge clk); #1;
      chk("hit_valid", hit_valid_o, v);
    end
    exp_cnt_q.push_back(m_cnt);
    exp_ovf_q.push_back(m_ovf);
    valid_i = 1'($urandom_range(0, 1));
    last_i  = 1'($urandom_range(0, 1));
    start_i = 1'($urandom_range(0, 1));
    chk("flush_ready", ready_o, 0);
    chk("flush_busy", busy_o, 1);
    chk("flush_done", done_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    chk("done_pulse", done_o, 1);
    chk("done_busy", busy_o, 0);
    chk("done_count", count_o, m_cnt);
    chk("done_ovf", ovf_o, m_ovf);
    chk("done_hit_valid", hit_valid_o, 0);
  endtask

  task automatic idle_tail(input int cycles);
    start_i = 1'b0;
    repeat (cycles) begin
      valid_i   = 1'($urandom_range(0, 1));
      covered_i = NSETS'($urandom);
      last_i    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("idle_done", done_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_ready", ready_o, 0);
      chk("idle_count", count_o, m_cnt);
      chk("idle_ovf", ovf_o, m_ovf);
      chk("idle_hit_valid", hit_valid_o, 0);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; mode_i = '0; mask_i = '0; k_i = '0;
    valid_i = 1'b0; covered_i = '0; last_i = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; m_mode = '0; m_mask = '0; m_k = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_hit_valid", hit_valid_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_tail(2);

    // reset in the middle of a run with five hits counted
    start_cfg(3'd0, 3'b111, 4'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) begin
      valid_i = 1'b1; covered_i = 3'b111; last_i = 1'b0;
      exp_hit_q.push_back(1'b1);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_count", count_o, 5);
    chk("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("midrst_count", count_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_hit_valid", hit_valid_o, 0);
    chk("midrst_done", done_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0; m_ovf = 1'b0;
    idle_tail(4);

    // legacy three-set EXACT k=2
    dir_cov = '{3'b111, 3'b110, 3'b011, 3'b101, 3'b100, 3'b000};
    start_cfg(3'd3, 3'b111, 4'd2);
    run_body(6, 1'b0);
    chk("legacy_count", count_o, 3);
    idle_tail(2);

    // mode sweep on covered 101
    for (int i = 0; i < 7; i++) begin
      dir_cov = '{3'b101};
      start_cfg(sw_mode[i], sw_mask[i], sw_k[i]);
      run_body(1, 1'b0);
      chk("sweep_count", count_o, sw_exp[i]);
      idle_tail(1);
    end

    // handshake gaps
    dir_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    dir_cov   = '{3'b111, 3'b111, 3'b111};
    start_cfg(3'd0, 3'b111, 4'd0);
    run_body(3, 1'b0);
    chk("gaps_count", count_o, 3);
    idle_tail(1);

    // saturation, then a fresh start must clear count and ovf
    for (int i = 0; i < CMAX + 5; i++) dir_cov.push_back(NSETS'($urandom_range(1, 7)));
    start_cfg(3'd0, 3'b111, 4'd0);
    run_body(CMAX + 5, 1'b0);
    chk("sat_count", count_o, CMAX);
    chk("sat_ovf", ovf_o, 1);
    idle_tail(2);

    // random runs, some restarted straight from DONE
    for (int r = 0; r < 25; r++) begin
      start_cfg(3'($urandom_range(0, 7)), NSETS'($urandom), K_W'($urandom_range(0, NSETS + 1)));
      run_body($urandom_range(1, 10), 1'b1);
      if (r == 24 || (r != 0 && $urandom_range(0, 1) == 0)) idle_tail(2);
    end

    @(posedge clk); #1;
    chk("hit_queue_drained", exp_hit_q.size(), 0);
    chk("count_queue_drained", exp_cnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
